fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 149 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared constants and state encoding for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned N_REQ      = 4;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned FULL_LVL   = 15;
  localparam int unsigned MAX_BURST  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StStall
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of valid searching from last_idx+1 upward, wrapping
// around so last_idx itself is the final candidate.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] last_idx,
  output logic [IDX_W-1:0] pick_idx,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    pick_idx = last_idx;
    found    = 1'b0;
    cand     = '0;
    // Walk farthest-to-nearest so the nearest valid port is the last one written.
    for (int off = int'(N); off >= 1; off--) begin
      cand = IDX_W'((int'(last_idx) + off) % int'(N));
      if (valid[cand]) begin
        pick_idx = cand;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging N_REQ producer streams into one FIFO write port, with
// bounded bursts and a shadow occupancy counter that stalls grants when the FIFO is full.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ     = fifo_arb_pkg::N_REQ,
  parameter int unsigned DATA_W    = fifo_arb_pkg::DATA_W,
  parameter int unsigned MAX_BURST = fifo_arb_pkg::MAX_BURST
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_rd,
  output logic                    fifo_write,
  output logic [DATA_W-1:0]       fifo_data,
  output logic [1:0]              grant_id,
  output logic                    grant_active,
  output logic [3:0]              occupancy
);

  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam int unsigned OCC_W   = $clog2(fifo_arb_pkg::FIFO_DEPTH);
  localparam int unsigned SUM_W   = OCC_W + 1;

  fifo_arb_pkg::arb_state_e state_q;

  logic [1:0]         grant_q;
  logic [1:0]         last_q;
  logic [BURST_W-1:0] burst_q;
  logic [OCC_W-1:0]   occ_q;
  logic               wr_q;
  logic [DATA_W-1:0]  data_q;

  logic               space;
  logic               space_nxt;
  logic               accept;
  logic               burst_end;
  logic               rearb;
  logic [BURST_W-1:0] burst_inc;
  logic [OCC_W-1:0]   occ_d;
  logic [DATA_W-1:0]  grant_word;
  logic [1:0]         pick_idx;
  logic               pick_found;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (2)
  ) u_rr_pick (
    .valid    (req_valid),
    .last_idx (last_q),
    .pick_idx (pick_idx),
    .found    (pick_found)
  );

  always_comb begin
    grant_word = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (grant_q == 2'(k)) begin
        grant_word = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // A word still in the write register counts against space; same-cycle reads do not.
  assign space = (SUM_W'(occ_q) + SUM_W'(wr_q)) < SUM_W'(fifo_arb_pkg::FULL_LVL);

  assign accept = (state_q == fifo_arb_pkg::StGrant) && space && req_valid[grant_q];

  always_comb begin
    occ_d = occ_q;
    if (wr_q && !fifo_rd) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!wr_q && fifo_rd && (occ_q != '0)) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  assign space_nxt = (SUM_W'(occ_d) + SUM_W'(accept)) < SUM_W'(fifo_arb_pkg::FULL_LVL);
  assign burst_inc = burst_q + BURST_W'(accept);
  assign burst_end = accept && (burst_inc == BURST_W'(MAX_BURST));
  assign rearb     = burst_end || !req_valid[grant_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= fifo_arb_pkg::StIdle;
      grant_q <= 2'd0;
      last_q  <= 2'd3;
      burst_q <= '0;
      occ_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      occ_q <= occ_d;
      wr_q  <= accept;
      if (accept) begin
        data_q <= grant_word;
      end
      unique case (state_q)
        fifo_arb_pkg::StIdle: begin
          if (pick_found) begin
            state_q <= fifo_arb_pkg::StGrant;
            grant_q <= pick_idx;
            last_q  <= pick_idx;
            burst_q <= '0;
          end
        end
        fifo_arb_pkg::StGrant: begin
          if (!pick_found) begin
            state_q <= fifo_arb_pkg::StIdle;
          end else begin
            // The picker also returns the current grantee when it is the only valid port.
            if (rearb) begin
              grant_q <= pick_idx;
              last_q  <= pick_idx;
              burst_q <= '0;
            end else begin
              burst_q <= burst_inc;
            end
            state_q <= space_nxt ? fifo_arb_pkg::StGrant : fifo_arb_pkg::StStall;
          end
        end
        fifo_arb_pkg::StStall: begin
          if (space_nxt) begin
            state_q <= fifo_arb_pkg::StGrant;
          end
        end
        default: state_q <= fifo_arb_pkg::StIdle;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    if ((state_q == fifo_arb_pkg::StGrant) && space) begin
      req_ready = N_REQ'(1) << grant_q;
    end
  end

  assign fifo_write   = wr_q;
  assign fifo_data    = data_q;
  assign grant_id     = grant_q;
  assign grant_active = (state_q != fifo_arb_pkg::StIdle);
  assign occupancy    = 4'(occ_q);

  assert property (@(posedge clock) disable iff (reset) $onehot0(req_ready));
  assert property (@(posedge clock) disable iff (reset)
                   occupancy <= 4'(fifo_arb_pkg::FULL_LVL));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producers drain per-port word tables, expected
// FIFO words are queued at issue time and a negedge monitor checks every write.
module tb_fifo_wr_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NP-1:0]    req_valid;
  logic [NP*DW-1:0] req_data;
  logic [NP-1:0]    req_ready;
  logic             fifo_rd;
  logic             fifo_write;
  logic [DW-1:0]    fifo_data;
  logic [1:0]       grant_id;
  logic             grant_active;
  logic [3:0]       occupancy;

  fifo_wr_arbiter #(
    .N_REQ     (4),
    .DATA_W    (16),
    .MAX_BURST (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_rd      (fifo_rd),
    .fifo_write   (fifo_write),
    .fifo_data    (fifo_data),
    .grant_id     (grant_id),
    .grant_active (grant_active),
    .occupancy    (occupancy)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] mem [NP][32];
  int            head [NP];
  int            tail [NP];
  logic [DW-1:0] exp_q [$];

  int n_pass   = 0;
  int n_total  = 0;
  bit mon_en   = 1'b0;
  bit acc_prev = 1'b0;
  int cyc      = 0;
  int wr_cnt   = 0;
  int first_wr = -1;
  int last_wr  = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive();
    for (int k = 0; k < int'(NP); k++) begin
      req_valid[k]          = head[k] < tail[k];
      req_data[k*DW +: DW]  = (head[k] < tail[k]) ? mem[k][head[k]] : '0;
    end
  endtask

  task automatic flush();
    for (int k = 0; k < int'(NP); k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    drive();
  endtask

  task automatic load(input int k, input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[k][tail[k]] = base + DW'(i);
      tail[k]++;
    end
    drive();
  endtask

  task automatic push_seq(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + DW'(i));
  endtask

  task automatic clr_cnt();
    wr_cnt   = 0;
    first_wr = -1;
    last_wr  = -1;
  endtask

  // One rising edge: record the handshake seen before it, then advance the producers.
  task automatic step();
    logic [NP-1:0] hs;
    @(negedge clock);
    hs = reset ? '0 : (req_valid & req_ready);
    @(posedge clock);
    #1;
    acc_prev = |hs;
    cyc++;
    for (int k = 0; k < int'(NP); k++) if (hs[k]) head[k]++;
    drive();
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      check("wr_latency", 32'(fifo_write), 32'(acc_prev));
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (req_ready != '0) check("ready_is_grantee", 32'(req_ready), 32'(4'b0001 << grant_id));
      if (fifo_write) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got data 0x%0h, expected no write", fifo_data);
        end else begin
          check("wr_data", 32'(fifo_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    req_valid = '0;
    req_data  = '0;
    fifo_rd   = 1'b0;
    reset     = 1'b1;
    flush();
    step();
    step();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_write", 32'(fifo_write), 32'd0);
    check("rst_data", 32'(fifo_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_active", 32'(grant_active), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single producer on port 2.
    clr_cnt();
    load(2, 16'hA001, 3);
    push_seq(16'hA001, 3);
    step();
    check("t2_grant_id", 32'(grant_id), 32'd2);
    check("t2_active", 32'(grant_active), 32'd1);
    check("t2_ready", 32'(req_ready), 32'b0100);
    repeat (6) step();
    check("t2_writes", 32'(wr_cnt), 32'd3);
    check("t2_span", 32'(last_wr - first_wr), 32'd2);
    check("t2_occ", 32'(occupancy), 32'd3);
    check("t2_idle", 32'(grant_active), 32'd0);

    fifo_rd = 1'b1;
    repeat (3) step();
    check("drain_occ", 32'(occupancy), 32'd0);
    step();
    check("rd_at_zero", 32'(occupancy), 32'd0);
    fifo_rd = 1'b0;

    // Fill to 7, then read and write in the same cycle.
    flush();
    clr_cnt();
    load(1, 16'h7100, 8);
    push_seq(16'h7100, 8);
    repeat (9) step();
    check("t3_occ7", 32'(occupancy), 32'd7);
    check("t3_wr_pending", 32'(fifo_write), 32'd1);
    fifo_rd = 1'b1;
    step();
    fifo_rd = 1'b0;
    check("t3_rw_same", 32'(occupancy), 32'd7);
    check("t3_writes", 32'(wr_cnt), 32'd8);
    fifo_rd = 1'b1;
    repeat (7) step();
    fifo_rd = 1'b0;
    check("t3_drained", 32'(occupancy), 32'd0);

    // Fairness from a fresh reset with a continuous reader.
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    flush();
    clr_cnt();
    fifo_rd = 1'b1;
    load(0, 16'hB000, 8);
    load(1, 16'hB100, 4);
    load(2, 16'hB200, 4);
    load(3, 16'hB300, 4);
    push_seq(16'hB000, 4);
    push_seq(16'hB100, 4);
    push_seq(16'hB200, 4);
    push_seq(16'hB300, 4);
    push_seq(16'hB004, 4);
    repeat (5) step();
    check("t4_second_grant", 32'(grant_id), 32'd1);
    repeat (19) step();
    fifo_rd = 1'b0;
    check("t4_writes", 32'(wr_cnt), 32'd20);
    check("t4_no_bubble", 32'(last_wr - first_wr), 32'd19);
    check("t4_occ", 32'(occupancy), 32'd0);
    check("t4_exp_empty", 32'(exp_q.size()), 32'd0);

    // Full stall with no reads, then one read pulse.
    flush();
    clr_cnt();
    load(0, 16'h5000, 17);
    push_seq(16'h5000, 16);
    repeat (20) step();
    check("t5_writes", 32'(wr_cnt), 32'd15);
    check("t5_occ_full", 32'(occupancy), 32'd15);
    check("t5_ready_low", 32'(req_ready), 32'd0);
    check("t5_active", 32'(grant_active), 32'd1);
    check("t5_grant_held", 32'(grant_id), 32'd0);
    load(1, 16'hC100, 1);
    fifo_rd = 1'b1;
    step();
    fifo_rd = 1'b0;
    check("t5_regained", 32'(req_ready), 32'b0001);
    step();
    check("t5_burst_resumes", 32'(grant_id), 32'd1);
    step();
    check("t5_one_more", 32'(wr_cnt), 32'd16);
    check("t5_occ_refull", 32'(occupancy), 32'd15);
    check("t5_ready_low2", 32'(req_ready), 32'd0);
    check("t5_exp_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the cycle after a port-1 acceptance.
    reset = 1'b1;
    step();
    reset = 1'b0;
    flush();
    clr_cnt();
    exp_q.delete();
    load(1, 16'hD100, 2);
    exp_q.push_back(16'hD100);
    step();
    check("t6_grant_p1", 32'(grant_id), 32'd1);
    step();
    reset = 1'b1;
    load(0, 16'hE000, 1);
    step();
    check("t6_no_write", 32'(fifo_write), 32'd0);
    check("t6_occ", 32'(occupancy), 32'd0);
    check("t6_active", 32'(grant_active), 32'd0);
    reset = 1'b0;
    exp_q.push_back(16'hE000);
    exp_q.push_back(16'hD101);
    step();
    check("t6_port0_first", 32'(grant_id), 32'd0);
    repeat (4) step();
    check("t6_writes", 32'(wr_cnt), 32'd3);
    check("t6_occ_after", 32'(occupancy), 32'd2);
    check("t6_exp_empty", 32'(exp_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
